mult_fast_param: RTL and testbench
==================================

MULT_FAST_PARAM -- requirements
Module: mult_fast_param

Interface
Parameters:
REQ-001 SHALL have parameter D, default 16: digit width in bits.
REQ-002 SHALL have parameter NA, default 2: number of D-bit digits in operand A.
REQ-003 SHALL have parameter NB, default 2: number of D-bit digits in operand B.

Ports:
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a new multiplication.
REQ-007 SHALL have port skip_en  input  1  1 = skip digit pairs with a zero digit; 0 = process all pairs.
REQ-008 SHALL have port a  input  D*NA  unsigned multiplicand.
REQ-009 SHALL have port b  input  D*NB  unsigned multiplier.
REQ-010 SHALL have port busy  output  1  high while partial products are being accumulated.
REQ-011 SHALL have port done  output  1  one-cycle pulse: product is final.
REQ-012 SHALL have port product  output  D*(NA+NB)  unsigned result register.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start SHALL be ignored in CALC.
REQ-015 On an accepted start edge, the block SHALL:
  - latch a, b and skip_en;
  - clear product to 0;
  - build digit masks MA[i] = (a digit i != 0) and MB[j] = (b digit j != 0), or all-ones when skip_en=0.
REQ-016 Let P = popcount(MA)*popcount(MB); on the start edge the next state SHALL be CALC if P>0, else DONE.
REQ-017 In CALC, each edge SHALL add (A_i*B_j) << (D*(i+j)) to product for exactly one enabled pair (i,j).
REQ-018 Pair order SHALL be j outer and i inner, both ascending, visiting only set bits of MB and MA.
REQ-019 The partial product SHALL be 2D bits wide; the accumulation SHALL be unsigned, full width, and SHALL never overflow.
REQ-020 After the edge that accumulates the last enabled pair, the state SHALL be DONE.
REQ-021 Latency SHALL be: done high exactly P+1 cycles after the start edge (1 cycle when P=0).
REQ-022 busy SHALL equal 1 exactly when the state is CALC; this SHALL hold for P cycles.
REQ-023 done SHALL equal 1 exactly when the state is DONE, for one cycle; the next state SHALL be IDLE, or CALC/DONE if start is accepted in that cycle.
REQ-024 product SHALL hold its value from DONE until the next accepted start.
REQ-025 Changes on a, b and skip_en after the start edge SHALL not affect the current operation.
REQ-026 With skip_en=0, latency SHALL be the constant NA*NB+1 regardless of operand values.
REQ-027 A start held high continuously SHALL produce back-to-back operations, each accepted in its DONE cycle.

Reset
REQ-028 While reset=0, the block SHALL asynchronously set state=IDLE, busy=0, done=0, product=0 and clear all latched operands, masks and indices.
REQ-029 Reset asserted mid-CALC SHALL abort the operation, with no done pulse.
REQ-030 After reset deasserts, the first accepted start SHALL behave as from power-up.

Verification
REQ-031 The bench SHALL cover: a=0x0000_1234, b=0x0000_5678, skip_en=1 -> busy 1 cycle, done 2 cycles after start, product=0x0000_0000_0626_0060.
REQ-032 The bench SHALL cover: a=0xFFFF_FFFF, b=0xFFFF_FFFF, skip_en=1 -> busy 4 cycles, done at start+5, product=0xFFFF_FFFE_0000_0001.
REQ-033 The bench SHALL cover: a=0x0000_0000, b=0x1234_5678, skip_en=1 -> no busy, done at start+1, product=0.
REQ-034 The bench SHALL cover: a=0x0001_0000, b=0x0000_0002, skip_en=0 -> busy 4 cycles, done at start+5, product=0x0000_0000_0002_0000; the same with skip_en=1 -> done at start+2.
REQ-035 The bench SHALL cover: reset pulled low in the 2nd CALC cycle of the 0xFFFF_FFFF case -> busy=0, done=0, product=0 immediately; a fresh start of 0x0000_0003 x 0x0000_0005 -> product=0xF at start+2.
REQ-036 The bench SHALL cover: start held high across two operations, with a and b changed mid-CALC -> first result uses the latched values, second operation is accepted in the DONE cycle, done pulses once per operation.

Source files
------------

// File: rtl/mult_fast_param.sv
// Multi-cycle digit-serial unsigned multiplier: accumulates one D x D partial
// product per clock, optionally skipping digit pairs that contain a zero digit.
module mult_fast_param #(
    parameter int D  = 16,
    parameter int NA = 2,
    parameter int NB = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  skip_en,
    input  logic [D*NA-1:0]       a,
    input  logic [D*NB-1:0]       b,
    output logic                  busy,
    output logic                  done,
    output logic [D*(NA+NB)-1:0]  product
);

    localparam int W  = D * (NA + NB);
    // One extra code per index so NA / NB can mean "no further set bit".
    localparam int IA = $clog2(NA + 1);
    localparam int IB = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [D*NA-1:0] a_r;
    logic [D*NB-1:0] b_r;
    logic [NA-1:0]   ma, ma_in;
    logic [NB-1:0]   mb, mb_in;
    logic [IA-1:0]   i_idx, i_start, i_after, i_wrap;
    logic [IB-1:0]   j_idx, j_start, j_after;
    logic            start_ok, has_work, last_pair;
    logic [D-1:0]    a_dig, b_dig;
    logic [2*D-1:0]  pp;
    logic [W-1:0]    pp_shift;

    function automatic logic [IA-1:0] scan_a(input logic [NA-1:0] m, input int from);
        scan_a = IA'(NA);
        for (int k = NA - 1; k >= 0; k--)
            if (m[k] && k >= from) scan_a = IA'(k);
    endfunction

    function automatic logic [IB-1:0] scan_b(input logic [NB-1:0] m, input int from);
        scan_b = IB'(NB);
        for (int k = NB - 1; k >= 0; k--)
            if (m[k] && k >= from) scan_b = IB'(k);
    endfunction

    // The masks are the latched form of skip_en: with skipping off they are all-ones.
    always_comb begin
        for (int i = 0; i < NA; i++) ma_in[i] = !skip_en || (a[D*i +: D] != '0);
        for (int j = 0; j < NB; j++) mb_in[j] = !skip_en || (b[D*j +: D] != '0);
    end

    assign start_ok = start && (state != CALC);
    assign has_work = (|ma_in) && (|mb_in);
    assign i_start  = scan_a(ma_in, 0);
    assign j_start  = scan_b(mb_in, 0);

    // Pair walk: i is the inner loop, wrapping to the first enabled A digit
    // whenever the next enabled B digit is taken.
    assign i_after   = scan_a(ma, int'(i_idx) + 1);
    assign i_wrap    = scan_a(ma, 0);
    assign j_after   = scan_b(mb, int'(j_idx) + 1);
    assign last_pair = (i_after == IA'(NA)) && (j_after == IB'(NB));

    assign a_dig    = a_r[D*int'(i_idx) +: D];
    assign b_dig    = b_r[D*int'(j_idx) +: D];
    assign pp       = (2*D)'(a_dig) * (2*D)'(b_dig);
    assign pp_shift = W'(pp) << (D * (int'(i_idx) + int'(j_idx)));

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = has_work ? CALC : DONE;
            CALC:    if (last_pair) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = has_work ? CALC : DONE;
                     else          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r     <= '0;
            b_r     <= '0;
            ma      <= '0;
            mb      <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            product <= '0;
        end else if (start_ok) begin
            a_r     <= a;
            b_r     <= b;
            ma      <= ma_in;
            mb      <= mb_in;
            i_idx   <= i_start;
            j_idx   <= j_start;
            product <= '0;
        end else if (state == CALC) begin
            product <= product + pp_shift;
            if (i_after == IA'(NA)) begin
                i_idx <= i_wrap;
                j_idx <= j_after;
            end else begin
                i_idx <= i_after;
            end
        end
    end

endmodule

// File: tb/tb_mult_fast_param.sv
// Directed bench for mult_fast_param: a reference model fills a scoreboard at
// each start; results, latency and busy length are compared when done pulses.
module tb_mult_fast_param;

    localparam int D  = 16;
    localparam int NA = 2;
    localparam int NB = 2;
    localparam int MAX_CYC = 64;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          busy_n;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        skip_en = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [63:0] product;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_fast_param #(.D(D), .NA(NA), .NB(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .skip_en (skip_en),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input string tag);
        exp_t m;
        int pa = 0;
        int pb = 0;
        for (int k = 0; k < NA; k++) if (!s || x[D*k +: D] != '0) pa++;
        for (int k = 0; k < NB; k++) if (!s || y[D*k +: D] != '0) pb++;
        m.prod   = 64'(x) * 64'(y);
        m.busy_n = pa * pb;
        m.lat    = pa * pb + 1;
        m.tag    = tag;
        return m;
    endfunction

    // Called at the negedge of the cycle in which start is high; returns at the
    // negedge where done is seen (or when the cycle budget runs out).
    task automatic wait_done(input logic hold, input logic chg,
                             input logic [31:0] na, input logic [31:0] nb,
                             output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < MAX_CYC) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (!hold) start = 1'b0;
                if (chg) begin
                    a = na;
                    b = nb;
                end
            end
            if (done) break;
            if (busy) busy_n++;
        end
        if (n >= MAX_CYC) check("timeout_done", 64'(done), 64'd1);
    endtask

    task automatic score(input int n, input int busy_n);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 64'(n), 64'(e.lat));
        check({e.tag, "_busy"}, 64'(busy_n), 64'(e.busy_n));
        check({e.tag, "_product"}, product, e.prod);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         input logic s, input string tag);
        int n, bn;
        @(negedge clk);
        a = x;
        b = y;
        skip_en = s;
        start = 1'b1;
        sb.push_back(model(x, y, s, tag));
        wait_done(1'b0, 1'b0, '0, '0, n, bn);
        score(n, bn);
        @(negedge clk);
        check({tag, "_done_once"}, 64'(done), 64'd0);
        check({tag, "_hold"}, product, 64'(x) * 64'(y));
    endtask

    initial begin
        int n, bn;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_op(32'h0000_1234, 32'h0000_5678, 1'b1, "small");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max");
        do_op(32'h0000_0000, 32'h1234_5678, 1'b1, "zero_a");
        do_op(32'h0001_0000, 32'h0000_0002, 1'b0, "noskip");
        do_op(32'h0001_0000, 32'h0000_0002, 1'b1, "skip");
        do_op(32'hABCD_0000, 32'h0000_00EF, 1'b0, "noskip_hi");

        // Abort in the second CALC cycle of the max case.
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        skip_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        reset = 1'b1;
        do_op(32'h0000_0003, 32'h0000_0005, 1'b1, "post_reset");

        // Start held high: operands change mid-CALC, second op starts in DONE.
        @(negedge clk);
        a = 32'h0002_0003;
        b = 32'h0004_0005;
        skip_en = 1'b1;
        start = 1'b1;
        sb.push_back(model(32'h0002_0003, 32'h0004_0005, 1'b1, "b2b_first"));
        wait_done(1'b1, 1'b1, 32'h0000_0007, 32'h0009_0000, n, bn);
        score(n, bn);
        sb.push_back(model(32'h0000_0007, 32'h0009_0000, 1'b1, "b2b_second"));
        wait_done(1'b0, 1'b0, '0, '0, n, bn);
        score(n, bn);
        @(negedge clk);
        check("b2b_idle_done", 64'(done), 64'd0);
        check("b2b_idle_busy", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
